txshift_frame: RTL and testbench

Parametrised UART-style transmit shift register, the successor to the fixed 8N1 transmitter. It serialises one word per frame in this order: a start bit, DATA_W data bits LSB-first, an optional parity bit, then 1 or 2 stop bits. Each bit lasts a runtime-programmable number of clock cycles. It sits between the APB register file (word source, valid/ready) and the serial pin driver.

---
 rtl/usrt_pkg.sv | 25 ++
 rtl/txshift_bitclk.sv | 30 +++
 rtl/txshift_frame.sv | 193 +++++++++++++++++++
 tb/tb_txshift_frame.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/usrt_pkg.sv
// Shared types for the UART-style serial blocks:
// frame states, data-width limits and frame settings.
package usrt_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  localparam int DATA_W_MIN = 5;
  localparam int DATA_W_MAX = 9;
  localparam int IDX_W      = $clog2(DATA_W_MAX);
  localparam int BAUD_W_MAX = 16;

  typedef struct packed {
    logic [BAUD_W_MAX-1:0] baud;
    logic                  parity_en;
    logic                  parity_odd;
    logic                  two_stop;
  } frame_cfg_t;

endpackage

// File: rtl/txshift_bitclk.sv
// Bit-time counter: counts 0..max(baud,1)-1 while run is high,
// pulses bit_end on the last cycle of each bit. Shared with the receiver.
module txshift_bitclk #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         run,
  input  logic [W-1:0] baud,
  output logic         bit_end
);

  logic [W-1:0] cnt;
  logic [W-1:0] last;

  // baud of 0 behaves as 1 cycle per bit
  assign last    = (baud == '0) ? '0 : baud - W'(1);
  assign bit_end = run && (cnt == last);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!run || bit_end) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/txshift_frame.sv
// Parametrised UART transmit shifter: start, DATA_W bits LSB-first,
// optional parity, 1/2 stop bits. TXSHIFT_HOLD_EN adds a one-word hold buffer.
module txshift_frame
  import usrt_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int BAUD_W = 14
) (
  input  logic              i_Pclk,
  input  logic              i_Presetn,
  input  logic [BAUD_W-1:0] i_Baud,
  input  logic              i_Parity_En,
  input  logic              i_Parity_Odd,
  input  logic              i_Two_Stop,
  input  logic              i_Valid,
  input  logic [DATA_W-1:0] i_Data,
  output logic              o_Ready,
  output logic              o_Tx_Serial,
  output logic              o_Busy,
  output logic              o_Done
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

  state_t                state;
  state_t                state_nx;
  frame_cfg_t            in_cfg;
  frame_cfg_t            ld_cfg;
  logic [DATA_W-1:0]     ld_data;
  logic [DATA_W-1:0]     sh;
  logic [BAUD_W_MAX-1:0] baud_q;
  logic                  par_en_q;
  logic                  two_stop_q;
  logic                  par_q;
  logic [IDX_W-1:0]      idx;
  logic                  stop_idx;
  logic                  bit_end;
  logic                  run;
  logic                  xfer;
  logic                  load;
  logic                  frame_end;
  logic                  last_stop;
  logic                  line_d;
  logic                  end_q;

  assign in_cfg = '{
    baud:       BAUD_W_MAX'(i_Baud),
    parity_en:  i_Parity_En,
    parity_odd: i_Parity_Odd,
    two_stop:   i_Two_Stop
  };

  assign xfer      = i_Valid && o_Ready;
  assign run       = state inside {START, DATA, PARITY, STOP};
  assign last_stop = !two_stop_q || stop_idx;
  assign frame_end = (state == STOP) && bit_end && last_stop;

`ifdef TXSHIFT_HOLD_EN
  logic              hold_full;
  logic [DATA_W-1:0] hold_data;
  frame_cfg_t        hold_cfg;

  assign o_Ready = !hold_full;

  // Load at IDLE or the last stop cycle; held word wins, else bypass
  always_comb begin
    load    = (state == IDLE || frame_end) && (hold_full || xfer);
    ld_data = hold_full ? hold_data : i_Data;
    ld_cfg  = hold_full ? hold_cfg : in_cfg;
  end

  always_ff @(posedge i_Pclk) begin
    if (!i_Presetn) begin
      hold_full <= 1'b0;
      hold_data <= '0;
      hold_cfg  <= '0;
    end else if (xfer && !(load && !hold_full)) begin
      hold_full <= 1'b1;
      hold_data <= i_Data;
      hold_cfg  <= in_cfg;
    end else if (load && hold_full) begin
      hold_full <= 1'b0;
    end
  end
`else
  assign o_Ready = (state == IDLE);

  always_comb begin
    load    = xfer;
    ld_data = i_Data;
    ld_cfg  = in_cfg;
  end
`endif

  txshift_bitclk #(
    .W(BAUD_W_MAX)
  ) u_bitclk (
    .clk    (i_Pclk),
    .rst_n  (i_Presetn),
    .run    (run),
    .baud   (baud_q),
    .bit_end(bit_end)
  );

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (load) state_nx = START;
      end
      START: begin
        if (bit_end) state_nx = DATA;
      end
      DATA: begin
        if (bit_end && idx == LAST_IDX) begin
          state_nx = par_en_q ? PARITY : STOP;
        end
      end
      PARITY: begin
        if (bit_end) state_nx = STOP;
      end
      STOP: begin
        if (frame_end) state_nx = load ? START : IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    line_d = 1'b1;
    case (state)
      START:   line_d = 1'b0;
      DATA:    line_d = sh[0];
      PARITY:  line_d = par_q;
      default: line_d = 1'b1;
    endcase
  end

  always_ff @(posedge i_Pclk) begin
    if (!i_Presetn) begin
      state       <= IDLE;
      o_Tx_Serial <= 1'b1;
      o_Busy      <= 1'b0;
      end_q       <= 1'b0;
      o_Done      <= 1'b0;
    end else begin
      state       <= state_nx;
      o_Tx_Serial <= line_d;
      o_Busy      <= (state != IDLE);
      end_q       <= frame_end;
      o_Done      <= end_q;
    end
  end

  // Parity accumulates as bits shift out, seeded with the odd flag
  always_ff @(posedge i_Pclk) begin
    if (!i_Presetn) begin
      sh         <= '0;
      par_q      <= 1'b0;
      baud_q     <= '0;
      par_en_q   <= 1'b0;
      two_stop_q <= 1'b0;
    end else if (load) begin
      sh         <= ld_data;
      par_q      <= ld_cfg.parity_odd;
      baud_q     <= ld_cfg.baud;
      par_en_q   <= ld_cfg.parity_en;
      two_stop_q <= ld_cfg.two_stop;
    end else if (state == DATA && bit_end) begin
      sh    <= sh >> 1;
      par_q <= par_q ^ sh[0];
    end
  end

  always_ff @(posedge i_Pclk) begin
    if (!i_Presetn) begin
      idx      <= '0;
      stop_idx <= 1'b0;
    end else begin
      if (state != DATA) begin
        idx <= '0;
      end else if (bit_end) begin
        idx <= (idx == LAST_IDX) ? '0 : idx + IDX_W'(1);
      end
      if (state != STOP) begin
        stop_idx <= 1'b0;
      end else if (bit_end) begin
        stop_idx <= !last_stop;
      end
    end
  end

endmodule

// File: tb/tb_txshift_frame.sv
// Random-stimulus bench for txshift_frame (DATA_W 8 and 5) against a
// frame-level model of the serial line; honours TXSHIFT_HOLD_EN.
module tb_txshift_frame;

`ifdef TXSHIFT_HOLD_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif

  typedef logic [1:0] fq_t[$];

  logic        clk = 1'b0;
  logic        rstn;
  logic        valid;
  logic        pe;
  logic        po;
  logic        ts;
  logic [13:0] baud;
  logic [7:0]  data;

  logic rdy8, tx8, bsy8, dn8;
  logic rdy5, tx5, bsy5, dn5;

  fq_t lq[2];
  fq_t hq[2];
  bit  er[2];
  bit  el[2];
  bit  eb[2];
  bit  ed[2];
  bit  plast[2];
  bit  xf[2];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  txshift_frame #(.DATA_W(8), .BAUD_W(14)) u_dut8 (
    .i_Pclk      (clk),
    .i_Presetn   (rstn),
    .i_Baud      (baud),
    .i_Parity_En (pe),
    .i_Parity_Odd(po),
    .i_Two_Stop  (ts),
    .i_Valid     (valid),
    .i_Data      (data),
    .o_Ready     (rdy8),
    .o_Tx_Serial (tx8),
    .o_Busy      (bsy8),
    .o_Done      (dn8)
  );

  txshift_frame #(.DATA_W(5), .BAUD_W(14)) u_dut5 (
    .i_Pclk      (clk),
    .i_Presetn   (rstn),
    .i_Baud      (baud),
    .i_Parity_En (pe),
    .i_Parity_Odd(po),
    .i_Two_Stop  (ts),
    .i_Valid     (valid),
    .i_Data      (data[4:0]),
    .o_Ready     (rdy5),
    .o_Tx_Serial (tx5),
    .o_Busy      (bsy5),
    .o_Done      (dn5)
  );

  task automatic chk(string tag, logic got, logic exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%b exp=%b t=%0t", tag, got, exp, $time);
    end
  endtask

  // One element per line cycle: bit0 = level, bit1 = last cycle of frame
  function automatic fq_t mk(int w, logic [7:0] d, logic [13:0] b,
                             bit p_en, bit p_odd, bit two);
    fq_t q;
    bit  bits[$];
    int  n;
    bit  par;
    n   = (b == 0) ? 1 : int'(b);
    par = p_odd;
    bits.push_back(1'b0);
    for (int i = 0; i < w; i++) begin
      bits.push_back(d[i]);
      par = par ^ d[i];
    end
    if (p_en) bits.push_back(par);
    bits.push_back(1'b1);
    if (two) bits.push_back(1'b1);
    for (int i = 0; i < bits.size(); i++) begin
      for (int j = 0; j < n; j++) begin
        q.push_back({(i == bits.size() - 1) && (j == n - 1), bits[i]});
      end
    end
    return q;
  endfunction

  task automatic model(int k, bit x);
    logic [1:0] v;
    fq_t        f;
    if (!rstn) begin
      lq[k].delete();
      hq[k].delete();
      el[k]    = 1'b1;
      eb[k]    = 1'b0;
      ed[k]    = 1'b0;
      plast[k] = 1'b0;
      er[k]    = 1'b1;
      return;
    end
    if (lq[k].size() == 0) begin
      v     = 2'b01;
      eb[k] = 1'b0;
    end else begin
      v     = lq[k].pop_front();
      eb[k] = 1'b1;
    end
    el[k]    = v[0];
    ed[k]    = plast[k];
    plast[k] = v[1];
    if (HOLD && lq[k].size() == 0 && hq[k].size() != 0) begin
      lq[k] = hq[k];
      hq[k].delete();
    end
    if (x) begin
      f = mk((k == 0) ? 8 : 5, data, baud, pe, po, ts);
      if (lq[k].size() == 0) lq[k] = f;
      else hq[k] = f;
    end
    er[k] = HOLD ? (hq[k].size() == 0) : (lq[k].size() == 0);
  endtask

  task automatic tick();
    for (int k = 0; k < 2; k++) begin
      xf[k] = rstn && valid && er[k];
      model(k, xf[k]);
    end
    @(posedge clk);
    @(negedge clk);
    chk("line8", tx8, el[0]);
    chk("busy8", bsy8, eb[0]);
    chk("done8", dn8, ed[0]);
    chk("ready8", rdy8, er[0]);
    chk("line5", tx5, el[1]);
    chk("busy5", bsy5, eb[1]);
    chk("done5", dn5, ed[1]);
    chk("ready5", rdy5, er[1]);
  endtask

  task automatic idle(int n);
    valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      data = 8'($urandom);
      baud = 14'($urandom_range(0, 5));
      pe   = 1'($urandom);
      po   = 1'($urandom);
      ts   = 1'($urandom);
      tick();
    end
  endtask

  task automatic send(logic [7:0] d, logic [13:0] b,
                      bit p_en, bit p_odd, bit two);
    bit got;
    got   = 1'b0;
    data  = d;
    baud  = b;
    pe    = p_en;
    po    = p_odd;
    ts    = two;
    valid = 1'b1;
    for (int i = 0; i < 400 && !got; i++) begin
      tick();
      got = xf[0];
    end
    valid = 1'b0;
    if (!got) begin
      total++;
      bad++;
      $display("FAIL send_timeout data=%h never accepted", d);
    end
  endtask

  initial begin
    rstn  = 1'b0;
    valid = 1'b0;
    data  = 8'h00;
    baud  = 14'd1;
    pe    = 1'b0;
    po    = 1'b0;
    ts    = 1'b0;
    er[0] = 1'b1;
    er[1] = 1'b1;
    @(negedge clk);
    tick();
    rstn = 1'b1;

    send(8'hA5, 14'd4, 1'b0, 1'b0, 1'b0);
    idle(45);
    send(8'hA5, 14'd2, 1'b1, 1'b0, 1'b1);
    idle(30);
    send(8'hA5, 14'd2, 1'b1, 1'b1, 1'b0);
    idle(30);
    send(8'h13, 14'd0, 1'b0, 1'b0, 1'b0);
    idle(12);
    send(8'h0F, 14'd3, 1'b0, 1'b0, 1'b0);
    idle(5);
    send(8'hF0, 14'd3, 1'b0, 1'b0, 1'b0);
    idle(80);

    send(8'h3C, 14'd2, 1'b0, 1'b0, 1'b0);
    idle(9);
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    send(8'h5A, 14'd1, 1'b1, 1'b0, 1'b0);
    idle(20);

    for (int i = 0; i < 4000; i++) begin
      rstn  = ($urandom_range(0, 399) != 0);
      valid = ($urandom_range(0, 2) == 0);
      data  = 8'($urandom);
      baud  = 14'($urandom_range(0, 5));
      pe    = 1'($urandom);
      po    = 1'($urandom);
      ts    = 1'($urandom);
      tick();
    end
    rstn = 1'b1;
    idle(120);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
